// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared state encoding, default sizing and width helper for the neuron datapath
package neuron_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_ACCUM   = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_FINISH  = 3'd4;

  localparam int DEF_N       = 16;
  localparam int DEF_NEURONS = 4;
  localparam int DEF_IDX_W   = 16;

  // Bits needed to count 0..n-1, never less than one so a single-value
  // counter still has a real bus.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/neuron_controller_if.sv
// rtl/neuron_controller_if.sv - run control, datapath strobes and result handshake (NEURON_CTRL_PERF_EN adds perf counters)
interface neuron_controller_if #(
  parameter int IDX_W = 16,
  parameter int NID_W = 2
) ();

  logic             start;
  logic             abort;
  logic             busy;
  logic             reg_rst;
  logic             ld;
  logic [IDX_W-1:0] index;
  logic [NID_W-1:0] neuron_id;
  logic             out_valid;
  logic             out_ready;
  logic             done;

`ifdef NEURON_CTRL_PERF_EN
  logic [31:0]      perf_cycles;
  logic [31:0]      perf_stall;

  modport master (
    input  start, abort, out_ready,
    output busy, reg_rst, ld, index, neuron_id, out_valid, done, perf_cycles, perf_stall
  );
  modport slave (
    output start, abort, out_ready,
    input  busy, reg_rst, ld, index, neuron_id, out_valid, done, perf_cycles, perf_stall
  );
`else
  modport master (
    input  start, abort, out_ready,
    output busy, reg_rst, ld, index, neuron_id, out_valid, done
  );
  modport slave (
    output start, abort, out_ready,
    input  busy, reg_rst, ld, index, neuron_id, out_valid, done
  );
`endif

endinterface

// File: rtl/term_counter.sv
// rtl/term_counter.sv - mod-N term counter with clear, enable and terminal-count flag
module term_counter #(
  parameter int N   = 16,
  parameter int K_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr_i,
  input  logic           en_i,
  output logic [K_W-1:0] k_o,
  output logic           tc_o
);

  logic [K_W-1:0] k_q, k_d;

  assign tc_o = (k_q == K_W'(N - 1));
  assign k_o  = k_q;

  // Clear wins over enable; wrap to zero after the terminal count.
  always_comb begin
    k_d = k_q;
    if (clr_i) begin
      k_d = '0;
    end else if (en_i) begin
      k_d = tc_o ? '0 : k_q + K_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q <= '0;
    end else begin
      k_q <= k_d;
    end
  end

endmodule

// File: rtl/neuron_controller.sv
// rtl/neuron_controller.sv - sequencer for the single-MAC neuron datapath; NEURON_CTRL_PERF_EN adds busy/stall counters
module neuron_controller
  import neuron_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int NEURONS = DEF_NEURONS,
  parameter int IDX_W   = DEF_IDX_W
) (
  input logic                 clk,
  input logic                 rst,
  neuron_controller_if.master bus
);

  localparam int NID_W = min1_clog2(NEURONS);
  localparam int K_W   = min1_clog2(N);

  logic [2:0]       state_q, state_d;
  logic [NID_W-1:0] neuron_id_q, neuron_id_d;
  logic [K_W-1:0]   k;
  logic             k_tc;
  logic             k_clr;
  logic             k_en;
  logic             aborting;
  logic             start_acc;
  logic             handshake;
  logic             last_nid;

  assign aborting  = bus.abort && (state_q != S_IDLE);
  assign start_acc = (state_q == S_IDLE) && bus.start && !bus.abort;
  assign handshake = (state_q == S_PRESENT) && bus.out_ready;
  assign last_nid  = (neuron_id_q == NID_W'(NEURONS - 1));

  // k is zeroed while entering CLEAR so index already points at the new
  // neuron's first term, and it parks on N-1 so PRESENT shows the last term.
  assign k_clr = (state_d == S_CLEAR);
  assign k_en  = (state_q == S_ACCUM) && !k_tc;

  term_counter #(
    .N   (N),
    .K_W (K_W)
  ) u_term_counter (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (k_clr),
    .en_i  (k_en),
    .k_o   (k),
    .tc_o  (k_tc)
  );

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_acc) state_d = S_CLEAR;
      S_CLEAR:   state_d = S_ACCUM;
      S_ACCUM:   if (k_tc) state_d = S_PRESENT;
      S_PRESENT: if (handshake) state_d = last_nid ? S_FINISH : S_CLEAR;
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (aborting) state_d = S_IDLE;
  end

  // Neuron id resets on start and advances on each non-final handshake.
  always_comb begin
    neuron_id_d = neuron_id_q;
    if (start_acc) begin
      neuron_id_d = '0;
    end else if (handshake && !aborting && !last_nid) begin
      neuron_id_d = neuron_id_q + NID_W'(1);
    end
  end

  // State and neuron id registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      neuron_id_q <= '0;
    end else begin
      state_q     <= state_d;
      neuron_id_q <= neuron_id_d;
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.reg_rst   = (state_q == S_CLEAR);
  assign bus.ld        = (state_q == S_ACCUM);
  assign bus.out_valid = (state_q == S_PRESENT);
  assign bus.done      = (state_q == S_FINISH);
  assign bus.neuron_id = neuron_id_q;
  assign bus.index     = IDX_W'(neuron_id_q) * IDX_W'(N) + IDX_W'(k);

`ifdef NEURON_CTRL_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Saturating busy and backpressure counters, restarted by each accepted start.
  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stall_d  = perf_stall_q;
    if (start_acc) begin
      perf_cycles_d = '0;
      perf_stall_d  = '0;
    end else begin
      if (bus.busy && (perf_cycles_q != 32'hFFFF_FFFF))
        perf_cycles_d = perf_cycles_q + 32'd1;
      if ((state_q == S_PRESENT) && !bus.out_ready && (perf_stall_q != 32'hFFFF_FFFF))
        perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  // Perf counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign bus.perf_cycles = perf_cycles_q;
  assign bus.perf_stall  = perf_stall_q;
`endif

endmodule
